// File: rtl/sramfifo_pkg.sv
// sramfifo_pkg: shared defaults for the multi-channel SRAM FIFO.
// RD_LAT is the request-to-rd_vld latency: one RAM address register plus one output register.
package sramfifo_pkg;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_CHBIT  = 2;
   localparam int DEF_SEGBIT = 4;
   localparam int RD_LAT     = 2;
endpackage

// File: rtl/sramfifo_ram.sv
// sramfifo_ram: simple dual-port RAM with a registered read address.
// There is no reset, so the contents survive rst.
module sramfifo_ram #(
   parameter int    WIDTH = 8,
   parameter int    AW    = 6,
   parameter string TYPE  = "AUTO"
)(
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);
   (* ram_style = TYPE *) logic [WIDTH-1:0] r_mem [2**AW];
   logic [AW-1:0] r_raddr;
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_raddr <= i_raddr;
   end
   assign o_rdata = r_mem[r_raddr];
endmodule

// File: rtl/sramfifo_mch.sv
// sramfifo_mch: NCH independent FIFOs sharing one RAM; each channel owns a SEG-word segment.
// Reads return two cycles after the request; flush clears a channel without error pulses.
module sramfifo_mch
   import sramfifo_pkg::*;
#(
   parameter int    WIDTH  = DEF_WIDTH,
   parameter int    CHBIT  = DEF_CHBIT,
   parameter int    SEGBIT = DEF_SEGBIT,
   parameter string TYPE   = "AUTO"
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [CHBIT-1:0]      wr_ch,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [CHBIT-1:0]      rd_ch,
   input  logic [2**CHBIT-1:0]   flush,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_vld,
   output logic [2**CHBIT-1:0]   full,
   output logic [2**CHBIT-1:0]   empty,
   output logic                  wr_err,
   output logic                  rd_err
);
   localparam int NCH = 2**CHBIT;
   localparam logic [SEGBIT:0] SEG_CNT = {1'b1, {SEGBIT{1'b0}}};
   logic [SEGBIT-1:0] r_wptr [NCH];
   logic [SEGBIT-1:0] r_rptr [NCH];
   logic [SEGBIT:0]   r_cnt [NCH];
   logic [SEGBIT:0]   w_cnt_nxt [NCH];
   logic [NCH-1:0]    r_full, r_empty;
   logic [RD_LAT-1:0] r_pipe;
   logic [WIDTH-1:0]  w_ram_q, r_rd_data;
   logic              r_wr_err, r_rd_err;
   logic              w_wr_ok, w_rd_ok;
   // Acceptance uses the registered flags, so a same-cycle opposite access never rescues it.
   assign w_wr_ok = wr_en & ~r_full[wr_ch] & ~flush[wr_ch];
   assign w_rd_ok = rd_en & ~r_empty[rd_ch] & ~flush[rd_ch];
   always_comb begin
      for (int i = 0; i < NCH; i++)
         w_cnt_nxt[i] = flush[i] ? '0 :
            r_cnt[i] + (SEGBIT+1)'(w_wr_ok && wr_ch == CHBIT'(i))
                     - (SEGBIT+1)'(w_rd_ok && rd_ch == CHBIT'(i));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
            r_cnt[i]  <= '0;
         end
         r_full    <= '0;
         r_empty   <= '1;
         r_pipe    <= '0;
         r_rd_data <= '0;
         r_wr_err  <= 1'b0;
         r_rd_err  <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i]   <= w_cnt_nxt[i];
            r_full[i]  <= w_cnt_nxt[i] == SEG_CNT;
            r_empty[i] <= w_cnt_nxt[i] == '0;
            if (flush[i]) begin
               r_wptr[i] <= '0;
               r_rptr[i] <= '0;
            end else begin
               if (w_wr_ok && wr_ch == CHBIT'(i)) r_wptr[i] <= r_wptr[i] + 1'b1;
               if (w_rd_ok && rd_ch == CHBIT'(i)) r_rptr[i] <= r_rptr[i] + 1'b1;
            end
         end
         r_pipe <= {r_pipe[RD_LAT-2:0], w_rd_ok};
         if (r_pipe[RD_LAT-2]) r_rd_data <= w_ram_q;
         r_wr_err <= wr_en & ~flush[wr_ch] & r_full[wr_ch];
         r_rd_err <= rd_en & ~flush[rd_ch] & r_empty[rd_ch];
      end
   end
   sramfifo_ram #(
      .WIDTH (WIDTH),
      .AW    (CHBIT + SEGBIT),
      .TYPE  (TYPE)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_ok),
      .i_waddr ({wr_ch, r_wptr[wr_ch]}),
      .i_wdata (wr_data),
      .i_re    (w_rd_ok),
      .i_raddr ({rd_ch, r_rptr[rd_ch]}),
      .o_rdata (w_ram_q)
   );
   assign rd_data = r_rd_data;
   assign rd_vld  = r_pipe[RD_LAT-1];
   assign full    = r_full;
   assign empty   = r_empty;
   assign wr_err  = r_wr_err;
   assign rd_err  = r_rd_err;
endmodule
